// File: rtl/ddr_lane_dly_ctrl_if.sv
// Command handshake between the training/calibration FSM and the lane delay sequencer.
// The command is accepted on cmd_valid & cmd_ready. Completion is reported with done, steps_done and err_lane.
interface ddr_lane_dly_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_lane;
    logic [1:0]       cmd_op;
    logic [TAP_W-1:0] cmd_steps;
    logic             done;
    logic [TAP_W-1:0] steps_done;
    logic             err_lane;

    modport master (
        output cmd_valid, cmd_lane, cmd_op, cmd_steps,
        input  cmd_ready, done, steps_done, err_lane
    );

    modport slave (
        input  cmd_valid, cmd_lane, cmd_op, cmd_steps,
        output cmd_ready, done, steps_done, err_lane
    );
endinterface

// File: rtl/ddr_lane_dly_ctrl.sv
// Per-lane IOD delay-line sequencer: load / step delay taps with fixed pulse spacing,
// track tap counts and latch sticky out-of-range errors.
module ddr_lane_dly_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int TAP_W       = 8,
    parameter int MAX_TAP     = 255,
    parameter int DEFAULT_TAP = 1,
    parameter int MOVE_GAP    = 4,
    parameter int LOAD_CYCLES = 2
) (
    input  logic                       fab_clk,
    input  logic                       arst,
    ddr_lane_dly_ctrl_if.slave         cmd,
    output logic [NUM_LANES-1:0]       delay_line_load,
    output logic [NUM_LANES-1:0]       delay_line_move,
    output logic [NUM_LANES-1:0]       delay_line_direction,
    input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
    output logic [NUM_LANES*TAP_W-1:0] tap_count,
    output logic [NUM_LANES-1:0]       oor_sticky,
    input  logic                       err_clr
);
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int WAIT_MAX = (MOVE_GAP > LOAD_CYCLES) ? MOVE_GAP : LOAD_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_DEF = TAP_W'(DEFAULT_TAP);

    typedef enum logic [2:0] {IDLE, LOAD, SETDIR, MOVE, GAP, FIN} state_t;

    state_t            state;
    logic [LANE_W-1:0] lane;
    logic              dir_up;
    logic [TAP_W-1:0]  steps_req;
    logic [TAP_W-1:0]  steps_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              abort_oor;
    logic [NUM_LANES-1:0] oor_q;
    logic [TAP_W-1:0]  taps [NUM_LANES];

    logic              lane_valid;
    logic [LANE_W-1:0] cmd_lane_idx;
    logic              at_limit;
    logic              gap_abort;
    logic              gap_end;
    logic              try_move;

    assign lane_valid   = ({1'b0, cmd.cmd_lane} < 5'(NUM_LANES));
    assign cmd_lane_idx = cmd.cmd_lane[LANE_W-1:0];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_pack
        assign tap_count[i*TAP_W +: TAP_W] = taps[i];
    end

    // A move may only be issued if it keeps the lane inside [0, MAX_TAP].
    always_comb begin
        at_limit  = dir_up ? (taps[lane] == TAP_MAX) : (taps[lane] == '0);
        gap_abort = abort_oor | oor_q[lane];
        gap_end   = (state == GAP) && (wait_cnt == WAIT_W'(MOVE_GAP));
        try_move  = (state == SETDIR) ||
                    (gap_end && !gap_abort && (steps_cnt != steps_req));
    end

    always_ff @(posedge fab_clk or posedge arst) begin
        if (arst) begin
            state                <= IDLE;
            lane                 <= '0;
            dir_up               <= 1'b0;
            steps_req            <= '0;
            steps_cnt            <= '0;
            wait_cnt             <= '0;
            abort_oor            <= 1'b0;
            oor_q                <= '0;
            oor_sticky           <= '0;
            delay_line_load      <= '0;
            delay_line_move      <= '0;
            delay_line_direction <= '0;
            cmd.cmd_ready        <= 1'b1;
            cmd.done             <= 1'b0;
            cmd.steps_done       <= '0;
            cmd.err_lane         <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                taps[i] <= TAP_DEF;
            end
        end else begin
            oor_q           <= delay_line_out_of_range;
            delay_line_move <= '0;
            cmd.done        <= 1'b0;
            cmd.err_lane    <= 1'b0;
            if (err_clr) begin
                oor_sticky <= '0;
            end

            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        lane          <= cmd_lane_idx;
                        steps_req     <= cmd.cmd_steps;
                        steps_cnt     <= '0;
                        abort_oor     <= 1'b0;
                        wait_cnt      <= WAIT_W'(1);
                        cmd.cmd_ready <= 1'b0;
                        if (!lane_valid || (cmd.cmd_op == 2'b11) ||
                            ((cmd.cmd_op != 2'b00) && (cmd.cmd_steps == '0))) begin
                            state          <= FIN;
                            cmd.done       <= 1'b1;
                            cmd.steps_done <= '0;
                            cmd.err_lane   <= !lane_valid;
                        end else if (cmd.cmd_op == 2'b00) begin
                            state                         <= LOAD;
                            delay_line_load[cmd_lane_idx] <= 1'b1;
                        end else begin
                            state                              <= SETDIR;
                            dir_up                             <= (cmd.cmd_op == 2'b01);
                            delay_line_direction[cmd_lane_idx] <= (cmd.cmd_op == 2'b01);
                        end
                    end
                end
                LOAD: begin
                    if (wait_cnt == WAIT_W'(LOAD_CYCLES)) begin
                        delay_line_load[lane] <= 1'b0;
                        taps[lane]            <= TAP_DEF;
                        state                 <= FIN;
                        cmd.done              <= 1'b1;
                        cmd.steps_done        <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MOVE: begin
                    state    <= GAP;
                    wait_cnt <= WAIT_W'(1);
                end
                GAP: begin
                    if (oor_q[lane]) begin
                        abort_oor <= 1'b1;
                    end
                    if (!gap_end) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (gap_abort) begin
                        state            <= FIN;
                        cmd.done         <= 1'b1;
                        cmd.steps_done   <= steps_cnt;
                        oor_sticky[lane] <= 1'b1;
                    end else if (steps_cnt == steps_req) begin
                        state          <= FIN;
                        cmd.done       <= 1'b1;
                        cmd.steps_done <= steps_cnt;
                    end
                end
                FIN: begin
                    state         <= IDLE;
                    cmd.cmd_ready <= 1'b1;
                end
                default: begin
                    state <= state;
                end
            endcase

            // Shared move issue for the first step (SETDIR) and every following step (end of GAP).
            if (try_move) begin
                if (at_limit) begin
                    state            <= FIN;
                    cmd.done         <= 1'b1;
                    cmd.steps_done   <= steps_cnt;
                    oor_sticky[lane] <= 1'b1;
                end else begin
                    delay_line_move[lane] <= 1'b1;
                    taps[lane]            <= dir_up ? (taps[lane] + 1'b1) : (taps[lane] - 1'b1);
                    steps_cnt             <= steps_cnt + 1'b1;
                    state                 <= MOVE;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr_lane_dly_ctrl.sv
// Self-checking bench for ddr_lane_dly_ctrl: directed vector table, hand-written corner
// sequences, then random commands against a transaction-level reference model.
module tb_ddr_lane_dly_ctrl;
    localparam int NL   = 4;
    localparam int TW   = 8;
    localparam int MAXT = 255;
    localparam int DEFT = 1;
    localparam int GAP  = 4;
    localparam int LC   = 2;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              err_clr = 1'b0;
    logic [NL-1:0]     dl_load;
    logic [NL-1:0]     dl_move;
    logic [NL-1:0]     dl_dir;
    logic [NL-1:0]     dl_oor = '0;
    logic [NL-1:0]     sticky;
    logic [NL*TW-1:0]  taps;

    ddr_lane_dly_ctrl_if #(.TAP_W(TW)) cmd_if ();

    ddr_lane_dly_ctrl #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT),
        .DEFAULT_TAP(DEFT), .MOVE_GAP(GAP), .LOAD_CYCLES(LC)
    ) dut (
        .fab_clk                 (clk),
        .arst                    (arst),
        .cmd                     (cmd_if.slave),
        .delay_line_load         (dl_load),
        .delay_line_move         (dl_move),
        .delay_line_direction    (dl_dir),
        .delay_line_out_of_range (dl_oor),
        .tap_count               (taps),
        .oor_sticky              (sticky),
        .err_clr                 (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int taps_m [NL];
    logic [NL-1:0] sticky_m;

    typedef struct {
        int          lane;
        int          op;
        int          steps;
        int          inj;
        int          exp_done;
        int          exp_steps;
        int          exp_err;
        logic [31:0] exp_taps;
        logic [3:0]  exp_sticky;
        int          clr_after;
    } vec_t;

    vec_t tbl [11];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [NL*TW-1:0] pack_model();
        logic [NL*TW-1:0] p;
        for (int i = 0; i < NL; i++) begin
            p[i*TW +: TW] = TW'(taps_m[i]);
        end
        return p;
    endfunction

    // Transaction-level reference: walk the requested steps with plain arithmetic.
    function automatic void model_cmd(input int lane, input int op, input int steps, input int inj,
                                      output int exp_done, output int exp_steps, output int exp_err);
        int n;
        bit up;
        exp_err   = (lane >= NL) ? 1 : 0;
        exp_steps = 0;
        if (lane >= NL || op == 3 || (op != 0 && steps == 0)) begin
            exp_done = 1;
            return;
        end
        if (op == 0) begin
            taps_m[lane] = DEFT;
            exp_done     = LC + 1;
            return;
        end
        up = (op == 1);
        n  = 0;
        while (n < steps) begin
            if ((up && taps_m[lane] == MAXT) || (!up && taps_m[lane] == 0)) begin
                sticky_m[lane] = 1'b1;
                break;
            end
            taps_m[lane] = up ? taps_m[lane] + 1 : taps_m[lane] - 1;
            n++;
            if (inj == n) begin
                sticky_m[lane] = 1'b1;
                break;
            end
        end
        exp_steps = n;
        exp_done  = 2 + n * (GAP + 1);
    endfunction

    task automatic applyStimulus(input int lane, input int op, input int steps, input int inj,
                                 input int exp_done, input int exp_steps, input int exp_err,
                                 input string tag);
        int  moves;
        int  loads;
        int  bad;
        int  done_rel;
        int  got_steps;
        int  got_err;
        int  w;
        bit  expect_move;
        expect_move = (lane < NL) && (op == 1 || op == 2) && (steps > 0);
        moves = 0; loads = 0; bad = 0; done_rel = -1; got_steps = -1; got_err = -1; w = 0;

        @(negedge clk);
        while (!cmd_if.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, " ready_before"}, cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_lane  = 4'(lane);
        cmd_if.cmd_op    = 2'(op);
        cmd_if.cmd_steps = TW'(steps);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;

        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1 && expect_move) begin
                checkOutput({tag, " direction"}, dl_dir[lane], (op == 1) ? 1 : 0);
            end
            if (cmd_if.cmd_ready) bad++;
            if (dl_move != '0) begin
                if (int'(dl_move) != (1 << lane) || k != 2 + moves * (GAP + 1)) bad++;
                moves++;
                if (inj > 0 && moves == inj && lane < NL) dl_oor[lane] = 1'b1;
            end
            if (dl_load != '0) begin
                if (int'(dl_load) != (1 << lane) || k > LC) bad++;
                loads++;
            end
            if (cmd_if.err_lane && !cmd_if.done) bad++;
            if (cmd_if.done) begin
                done_rel  = k;
                got_steps = int'(cmd_if.steps_done);
                got_err   = int'(cmd_if.err_lane);
                break;
            end
        end
        dl_oor = '0;

        checkOutput({tag, " done_latency"}, done_rel, exp_done);
        checkOutput({tag, " steps_done"}, got_steps, exp_steps);
        checkOutput({tag, " err_lane"}, got_err, exp_err);
        checkOutput({tag, " move_pulses"}, moves, exp_steps);
        checkOutput({tag, " load_pulses"}, loads, (op == 0 && lane < NL) ? LC : 0);
        checkOutput({tag, " pulse_protocol"}, bad, 0);
    endtask

    initial begin
        int ed, es, ee, lane, op, steps, inj, quiet;

        tbl[0]  = '{2, 1, 3,   0, 17,   3,   0, 32'h01040101, 4'b0000, 0};
        tbl[1]  = '{0, 2, 5,   0, 7,    1,   0, 32'h01040100, 4'b0001, 1};
        tbl[2]  = '{3, 1, 9,   0, 47,   9,   0, 32'h0A040100, 4'b0000, 0};
        tbl[3]  = '{3, 0, 1,   0, 3,    0,   0, 32'h01040100, 4'b0000, 0};
        tbl[4]  = '{1, 1, 8,   2, 12,   2,   0, 32'h01040300, 4'b0010, 0};
        tbl[5]  = '{6, 1, 0,   0, 1,    0,   1, 32'h01040300, 4'b0010, 0};
        tbl[6]  = '{2, 3, 5,   0, 1,    0,   0, 32'h01040300, 4'b0010, 0};
        tbl[7]  = '{1, 2, 0,   0, 1,    0,   0, 32'h01040300, 4'b0010, 0};
        tbl[8]  = '{0, 1, 255, 0, 1277, 255, 0, 32'h010403FF, 4'b0010, 0};
        tbl[9]  = '{0, 1, 1,   0, 2,    0,   0, 32'h010403FF, 4'b0011, 0};
        tbl[10] = '{2, 2, 2,   0, 12,   2,   0, 32'h010203FF, 4'b0011, 0};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_lane  = '0;
        cmd_if.cmd_op    = 2'b11;
        cmd_if.cmd_steps = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset ready", cmd_if.cmd_ready, 1);
        checkOutput("reset taps", taps, 32'h01010101);
        checkOutput("reset sticky", sticky, 0);
        checkOutput("reset pulses", {dl_load, dl_move, dl_dir}, 0);
        checkOutput("reset done", {cmd_if.done, cmd_if.err_lane}, 0);
        checkOutput("reset steps_done", cmd_if.steps_done, 0);
        arst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].lane, tbl[i].op, tbl[i].steps, tbl[i].inj,
                          tbl[i].exp_done, tbl[i].exp_steps, tbl[i].exp_err, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d taps", i), taps, tbl[i].exp_taps);
            checkOutput($sformatf("vec%0d sticky", i), sticky, tbl[i].exp_sticky);
            if (tbl[i].clr_after != 0) begin
                @(negedge clk) err_clr = 1'b1;
                @(negedge clk) err_clr = 1'b0;
                checkOutput($sformatf("vec%0d sticky_clr", i), sticky, 0);
            end
        end

        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        checkOutput("err_clr sticky", sticky, 0);

        // Lane 0 sits at MAX_TAP: the abort sets its sticky bit on the same edge err_clr is high.
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_lane  = 4'd0;
        cmd_if.cmd_op    = 2'b01;
        cmd_if.cmd_steps = TW'(1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        checkOutput("set_wins done", cmd_if.done, 1);
        checkOutput("set_wins sticky", sticky, 4'b0001);
        checkOutput("set_wins steps_done", cmd_if.steps_done, 0);

        // Reset in the middle of a 4-step increment (inside the first GAP).
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_lane  = 4'd2;
        cmd_if.cmd_op    = 2'b01;
        cmd_if.cmd_steps = TW'(4);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midcmd busy", cmd_if.cmd_ready, 0);
        arst = 1'b1;
        #1;
        checkOutput("arst ready", cmd_if.cmd_ready, 1);
        checkOutput("arst pulses", {dl_load, dl_move, dl_dir}, 0);
        checkOutput("arst done", {cmd_if.done, cmd_if.err_lane}, 0);
        checkOutput("arst steps_done", cmd_if.steps_done, 0);
        checkOutput("arst sticky", sticky, 0);
        checkOutput("arst taps", taps, 32'h01010101);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dl_move != '0 || dl_load != '0 || cmd_if.done || !cmd_if.cmd_ready) quiet++;
        end
        checkOutput("post_reset quiet", quiet, 0);
        checkOutput("post_reset taps", taps, 32'h01010101);

        for (int i = 0; i < NL; i++) taps_m[i] = DEFT;
        sticky_m = '0;

        for (int n = 0; n < 40; n++) begin
            lane  = int'($urandom_range(0, 5));
            op    = int'($urandom_range(0, 3));
            steps = int'($urandom_range(0, 12));
            inj   = 0;
            if (lane < NL && (op == 1 || op == 2) && steps > 0 && $urandom_range(0, 3) == 0) begin
                inj = int'($urandom_range(1, steps));
            end
            model_cmd(lane, op, steps, inj, ed, es, ee);
            applyStimulus(lane, op, steps, inj, ed, es, ee, $sformatf("rnd%0d", n));
            checkOutput($sformatf("rnd%0d taps", n), taps, pack_model());
            checkOutput($sformatf("rnd%0d sticky", n), sticky, sticky_m);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk) err_clr = 1'b1;
                @(negedge clk) err_clr = 1'b0;
                sticky_m = '0;
                checkOutput($sformatf("rnd%0d sticky_clr", n), sticky, sticky_m);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
